// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin arbiter feeding requester hex words to one UART transmitter
module uart_tx_scheduler #(
    parameter int N_REQ       = 2,
    parameter int DIGIT_COUNT = 4,
    parameter int APPEND_CRLF = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               req,
    input  logic [N_REQ*DIGIT_COUNT*4-1:0] data_in,
    output logic [N_REQ-1:0]               grant,
    output logic [7:0]                     tx_data,
    output logic                           tx_start,
    input  logic                           tx_busy,
    output logic                           busy
);

    localparam int WORD_W  = DIGIT_COUNT * 4;
    localparam int N_CHARS = DIGIT_COUNT + 2 * APPEND_CRLF;
    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int IDX_W   = $clog2(N_CHARS + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_WAIT_HI = 2'd2;
    localparam logic [1:0] S_WAIT_LO = 2'd3;

    logic [1:0]        r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_word;
    logic [N_REQ-1:0]  r_grant;
    logic [7:0]        r_tx_data;
    logic              r_tx_start;
    logic              r_busy;

    logic              w_found;
    logic [PTR_W-1:0]  w_win;
    logic [3:0]        w_nib;
    logic [7:0]        w_char;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        logic [PTR_W-1:0] v_i;
        w_found = 1'b0;
        w_win   = r_ptr;
        v_i     = r_ptr;
        for (int k = 1; k <= N_REQ; k++) begin
            v_i = PTR_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && req[v_i]) begin
                w_found = 1'b1;
                w_win   = v_i;
            end
        end
    end

    // Nibble 0 goes out first so the receive side rebuilds the word in order.
    always_comb begin
        w_nib = 4'h0;
        if (r_idx < IDX_W'(DIGIT_COUNT)) begin
            w_nib = r_word[r_idx*4 +: 4];
        end
        if (r_idx < IDX_W'(DIGIT_COUNT)) begin
            w_char = hex_ascii(w_nib);
        end else if (r_idx == IDX_W'(DIGIT_COUNT)) begin
            w_char = 8'h0D;
        end else begin
            w_char = 8'h0A;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= PTR_W'(N_REQ - 1);
            r_idx      <= '0;
            r_word     <= '0;
            r_grant    <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_grant    <= '0;
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_word  <= data_in[w_win*WORD_W +: WORD_W];
                        r_grant <= N_REQ'(1) << w_win;
                        r_ptr   <= w_win;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= w_char;
                        r_state    <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (r_idx == IDX_W'(N_CHARS - 1)) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_START;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant    = r_grant;
    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - randomized scoreboard bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    localparam int N = 2;
    localparam int D = 4;
    localparam int LIMIT = 8000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*D*4-1:0] data_in = '0;
    logic [N-1:0]     grant;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             tx_busy = 1'b0;
    logic             busy;

    logic [N-1:0]     req2 = '0;
    logic [N*D*4-1:0] data2 = '0;
    logic [N-1:0]     grant2;
    logic [7:0]       tx_data2;
    logic             tx_start2;
    logic             tx_busy2 = 1'b0;
    logic             busy2;

    uart_tx_scheduler #(.N_REQ(N), .DIGIT_COUNT(D), .APPEND_CRLF(1)) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in), .grant(grant),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy)
    );

    uart_tx_scheduler #(.N_REQ(N), .DIGIT_COUNT(D), .APPEND_CRLF(0)) dut_nocrlf (
        .clk(clk), .reset(reset), .req(req2), .data_in(data2), .grant(grant2),
        .tx_data(tx_data2), .tx_start(tx_start2), .tx_busy(tx_busy2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] rq0[$], rq1[$];
    logic [15:0] bq0[$], bq1[$];
    int          exp_grant[$];
    logic [7:0]  exp_char[$];
    logic [7:0]  exp2[$];
    int          m_ptr = N - 1;
    int          tx_mode = 0;
    int          n_start = 0;
    int          n_start2 = 0;
    bit          lat_chk = 1'b1;
    logic        prev_busy = 1'b0, prev_start = 1'b0, prev_txbusy = 1'b0, prev_txbusy2 = 1'b0;
    logic [N-1:0] prev_grant = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        string s = "0123456789ABCDEF";
        return s[n];
    endfunction

    task automatic expect_word(input int id, input logic [15:0] w);
        exp_grant.push_back(id);
        for (int k = 0; k < D; k++) exp_char.push_back(hexc(w[4*k +: 4]));
        exp_char.push_back(8'h0D);
        exp_char.push_back(8'h0A);
    endtask

    task automatic add(input int id, input logic [15:0] w);
        if (id == 0) bq0.push_back(w);
        else bq1.push_back(w);
    endtask

    // Reference: serve pending words round-robin, then release them to the requesters.
    task automatic commit();
        logic [15:0] t0[$], t1[$];
        t0 = bq0;
        t1 = bq1;
        while (t0.size() + t1.size() > 0) begin
            for (int k = 1; k <= N; k++) begin
                int i = (m_ptr + k) % N;
                if (i == 0 && t0.size() > 0) begin expect_word(0, t0.pop_front()); m_ptr = 0; break; end
                if (i == 1 && t1.size() > 0) begin expect_word(1, t1.pop_front()); m_ptr = 1; break; end
            end
        end
        foreach (bq0[j]) rq0.push_back(bq0[j]);
        foreach (bq1[j]) rq1.push_back(bq1[j]);
        bq0.delete();
        bq1.delete();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_grant.size() != 0 || exp_char.size() != 0 || busy) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < LIMIT), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_starts(input int target);
        int n = 0;
        while (n_start < target && n < LIMIT) begin @(negedge clk); n++; end
        check("wait_start", 32'(n < LIMIT), 1);
    endtask

    // Requesters hold req while they have a word queued; a grant retires the head word.
    always @(negedge clk) begin
        if (grant[0] && rq0.size() > 0) void'(rq0.pop_front());
        if (grant[1] && rq1.size() > 0) void'(rq1.pop_front());
        req = {rq1.size() != 0, rq0.size() != 0};
        data_in = {(rq1.size() != 0) ? rq1[0] : 16'h0, (rq0.size() != 0) ? rq0[0] : 16'h0};
    end

    // UART transmitter: busy rises 1-2 cycles after tx_start and stays high for a while.
    always begin
        int d, h;
        @(posedge clk); #2;
        if (tx_start) begin
            d = (tx_mode == 1) ? 2 : (tx_mode == 2) ? 1 : int'($urandom_range(1, 2));
            h = (tx_mode == 1) ? 50 : (tx_mode == 2) ? 5 : int'($urandom_range(1, 6));
            if (d == 2) begin @(posedge clk); #2; end
            tx_busy = 1'b1;
            repeat (h) @(posedge clk);
            #2;
            tx_busy = 1'b0;
        end
    end

    always begin
        @(posedge clk); #2;
        if (tx_start2) begin
            tx_busy2 = 1'b1;
            repeat (3) @(posedge clk);
            #2;
            tx_busy2 = 1'b0;
        end
    end

    always @(negedge clk) begin
        int e;
        if (!reset) begin
            if (grant != '0) begin
                check("grant_onehot", 32'($countones(grant)), 1);
                check("grant_after_idle", 32'(prev_busy), 0);
                check("busy_with_grant", 32'(busy), 1);
                if (exp_grant.size() == 0) check("grant_unexpected", 32'(grant), 0);
                else begin
                    e = exp_grant.pop_front();
                    check("grant_id", 32'(grant), 32'(1) << e);
                end
            end
            if (lat_chk && prev_grant != '0) check("start_latency", 32'(tx_start), 1);
            if (tx_start) begin
                n_start++;
                check("start_while_busy", 32'(prev_txbusy), 0);
                check("start_pulse", 32'(prev_start), 0);
                if (exp_char.size() == 0) check("start_unexpected", {24'h0, tx_data}, 32'hFFFF);
                else check("tx_data", {24'h0, tx_data}, {24'h0, exp_char.pop_front()});
            end
            if (grant2 != '0) check("grant2", 32'(grant2), 1);
            if (tx_start2) begin
                n_start2++;
                check("start2_while_busy", 32'(prev_txbusy2), 0);
                if (exp2.size() == 0) check("start2_unexpected", {24'h0, tx_data2}, 32'hFFFF);
                else check("tx_data2", {24'h0, tx_data2}, {24'h0, exp2.pop_front()});
            end
        end
        prev_busy = busy;
        prev_start = tx_start;
        prev_grant = grant;
        prev_txbusy = tx_busy;
        prev_txbusy2 = tx_busy2;
    end

    initial begin
        int n, base;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        @(negedge clk);

        add(0, 16'h1A2F);
        commit();
        drain("single_word");

        for (int r = 0; r < 2; r++) begin add(0, 16'($urandom)); add(1, 16'($urandom)); end
        commit();
        drain("round_robin");

        add(0, 16'($urandom));
        commit();
        wait_starts(n_start + 2);
        add(1, 16'($urandom));
        commit();
        drain("late_request");

        for (int b = 0; b < 6; b++) begin
            int c0 = int'($urandom_range(0, 2));
            int c1 = int'($urandom_range(0, 2));
            if (c0 + c1 == 0) c0 = 1;
            for (int j = 0; j < c0; j++) add(0, 16'($urandom));
            for (int j = 0; j < c1; j++) add(1, 16'($urandom));
            commit();
            drain("random_batch");
        end

        tx_mode = 1;
        add(0, 16'($urandom));
        add(1, 16'($urandom));
        commit();
        drain("slow_tx");

        tx_mode = 2;
        lat_chk = 1'b0;
        add(0, 16'($urandom));
        commit();
        base = n_start;
        wait_starts(base + 2);
        n = 0;
        while (!tx_busy && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_grant", 32'(grant), 0);
        check("midrst_tx_start", 32'(tx_start), 0);
        check("midrst_tx_data", 32'(tx_data), 0);
        check("midrst_busy", 32'(busy), 0);
        rq0.delete();
        rq1.delete();
        exp_grant.delete();
        exp_char.delete();
        m_ptr = N - 1;
        reset = 1'b0;
        @(negedge clk);
        add(0, 16'($urandom));
        add(1, 16'($urandom));
        commit();
        drain("after_reset_both");
        add(1, 16'($urandom));
        commit();
        drain("after_reset_req1");
        tx_mode = 0;
        lat_chk = 1'b1;

        exp2.push_back(8'h46);
        exp2.push_back(8'h30);
        exp2.push_back(8'h41);
        exp2.push_back(8'h39);
        data2 = {16'h0, 16'h9A0F};
        req2 = 2'b01;
        n = 0;
        while (grant2 == '0 && n < 20) begin @(negedge clk); n++; end
        req2 = '0;
        n = 0;
        while ((exp2.size() != 0 || busy2) && n < LIMIT) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        check("nocrlf_chars", 32'(n_start2), 4);
        check("nocrlf_left", 32'(exp2.size()), 0);

        check("sb_grants_left", 32'(exp_grant.size()), 0);
        check("sb_chars_left", 32'(exp_char.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single UART transmitter among `N_REQ` requesters. Each requester submits a `DIGIT_COUNT`-nibble hex word. The block captures the winning word, converts each nibble to an uppercase ASCII hex character, and sequences the characters into the UART TX byte interface, optionally followed by CR LF. Digit order matches the receive-side input manager (nibble `[3:0]` first), so an echoed word is reassembled identically on loopback.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters (2..8).
- `DIGIT_COUNT`, 4: hex digits per word.
- `APPEND_CRLF`, 1: when 1, send 0x0D then 0x0A after the last digit.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester request level; held until granted.
- `data_in`  in  N_REQ*DIGIT_COUNT*4  requester i word at `[i*DIGIT_COUNT*4 +: DIGIT_COUNT*4]`.
- `grant`  out  N_REQ  one-cycle one-hot pulse: that requester's word was captured.
- `tx_data`  out  8  byte to the UART transmitter; valid while `tx_start` is high.
- `tx_start`  out  1  one-cycle start pulse to the UART transmitter.
- `tx_busy`  in  1  UART transmitter busy; rises within 1–2 cycles of `tx_start`, falls when the stop bit completes.
- `busy`  out  1  high from grant until the final character's `tx_busy` falls.

## Operation
- Reset values: `grant`=0, `tx_start`=0, `tx_data`=0, `busy`=0, state=IDLE, char index=0, round-robin pointer=N_REQ-1 (requester 0 wins first).
- Arbitration happens only in IDLE.
  - Search order is pointer+1, pointer+2, … modulo N_REQ. The first asserted `req` wins.
  - The winner's slice of `data_in` is latched into a word register, and the pointer is set to the winner.
  - Requests arriving while not in IDLE wait. No preemption.
- Character sequence: nibble k = word[4k+3:4k] for k = 0..DIGIT_COUNT-1, then CR and LF if `APPEND_CRLF`.
  - Total characters L = DIGIT_COUNT + 2*APPEND_CRLF.
- Nibble encoding: 0–9 map to 0x30–0x39; A–F map to 0x41–0x46.
- FSM states:
  - IDLE: if `req`≠0, capture the word, pulse `grant`, clear char index, go to START.
  - START: if `tx_busy`=0, assert `tx_start` with `tx_data` = char[index] and go to WAIT_HI. Otherwise stay.
  - WAIT_HI: stay until `tx_busy`=1, then go to WAIT_LO.
  - WAIT_LO: stay until `tx_busy`=0. Then, if index=L-1, go to IDLE; otherwise increment index and go to START.
- `tx_data` holds the last sent character until the next `tx_start`.
- Reset in any state returns to IDLE in the same edge. A partially sent word is discarded and is not re-sent. The pointer returns to N_REQ-1.
- A `req` deasserted before its grant is simply not served. Dropping `req` after grant has no effect on the word in flight.

## Timing
- Edge e0 samples `req`≠0 in IDLE. `grant` is high during the cycle after e0, and `busy` rises at the same time.
- The next edge, with `tx_busy`=0, produces `tx_start` high for exactly 1 cycle.
  - First `tx_start` follows the cycle after `grant`: 2 cycles of latency from the `req` sampling edge when the transmitter is idle.
- Between successive characters: `tx_start` occurs 1 cycle after the edge that sees `tx_busy` fall. The START state adds one cycle in which `tx_busy`=0 is checked.
- `busy` falls on the same edge as the return to IDLE. A pending request is granted on the following edge, giving 1 idle cycle between words.
- A `tx_start` pulse is never issued while `tx_busy`=1.
- At most one `grant` bit is high in any cycle.

## Test plan
- Single word: req=01, requester 0 data 0x1A2F.
  - `grant`=01 once.
  - `tx_data` sequence 0x46,0x32,0x41,0x31,0x0D,0x0A with 6 `tx_start` pulses, each gated by `tx_busy` fall.
  - `busy` falls after the 6th character.
- Round-robin fairness: `req`=11 held continuously for 4 words.
  - Grant order is 0,1,0,1.
  - Each word is fully sent before the next `grant`.
- Late request: `req[1]` rises mid-transmission of requester 0's word.
  - No `grant` until requester 0's last character completes.
  - `grant[1]` is the first grant pulse after `busy` falls.
- Digit encoding: word 0x9A0F with APPEND_CRLF=0.
  - Characters 0x46,0x30,0x41,0x39; no CR/LF.
- Reset mid-word: assert `reset` during WAIT_LO of the 2nd character.
  - Next cycle all outputs are 0.
  - With `req`=10 afterward, requester 1 is granted (pointer reset), and its word starts from nibble 0.
- Slow transmitter: `tx_busy` delayed 2 cycles after `tx_start` and held for 50 cycles.
  - Exactly one `tx_start` per character.
  - No `tx_start` while `tx_busy`=1.
